// File: rtl/led_seq_pkg.sv
// ============================================================================
// Module   : led_seq_pkg
// Purpose  : Shared types and helpers for the LED sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_seq_pkg;

  localparam int N_MODES = 4;

  typedef enum logic [1:0] {
    COUNT  = 2'd0,
    RUN    = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;

  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(2'((int'(m) + 1) % N_MODES));
  endfunction

  // Every mode's entry pattern is either all-off or a single lit LSB.
  function automatic logic init_lsb(input mode_t m);
    return (m == RUN) || (m == BOUNCE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rise_detect.sv
// ============================================================================
// Module   : rise_detect
// Purpose  : Rising-edge pulse from a level; optional 2-flop synchronizer
//            when LED_SEQ_SYNC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic level_in,
  output logic rise
);

  logic w_level;
  logic r_hist;

`ifdef LED_SEQ_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], level_in};
    end
  end

  assign w_level = r_sync[1];
`else
  assign w_level = level_in;
`endif

  // History tracks the level during reset too, so a level already high at
  // release is not mistaken for an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hist <= w_level;
    end else begin
      r_hist <= w_level;
    end
  end

  assign rise = w_level & ~r_hist;

endmodule

`default_nettype wire

// File: rtl/led_sequencer.sv
// ============================================================================
// Module   : led_sequencer
// Purpose  : Steps an LED pattern (count/run/bounce/blink) on slow-tick edges.
//            Optional input synchronizers: define LED_SEQ_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int W_LED = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             mode_next,
  input  logic             pause,
  output logic [W_LED-1:0] leds,
  output logic [1:0]       mode,
  output logic             step_strobe
);

  logic             w_step;
  logic             w_req;
  mode_t            w_mode_nxt;
  logic [W_LED-1:0] w_next_leds;
  dir_t             w_next_dir;

  logic [W_LED-1:0] r_leds;
  mode_t            r_mode;
  dir_t             r_dir;
  logic             r_strobe;

  rise_detect u_tick_rise (
    .clock    (clock),
    .reset    (reset),
    .level_in (tick_in),
    .rise     (w_step)
  );

  rise_detect u_mode_rise (
    .clock    (clock),
    .reset    (reset),
    .level_in (mode_next),
    .rise     (w_req)
  );

  assign w_mode_nxt = next_mode(r_mode);

  always_comb begin
    w_next_leds = r_leds;
    w_next_dir  = r_dir;
    case (r_mode)
      COUNT:  w_next_leds = r_leds + W_LED'(1);
      RUN:    w_next_leds = {r_leds[W_LED-2:0], r_leds[W_LED-1]};
      BOUNCE: begin
        // Turn around on reaching an end so the end LED is not shown twice.
        if (r_dir == LEFT) begin
          if (r_leds[W_LED-1]) begin
            w_next_dir  = RIGHT;
            w_next_leds = r_leds >> 1;
          end else begin
            w_next_leds = r_leds << 1;
          end
        end else begin
          if (r_leds[0]) begin
            w_next_dir  = LEFT;
            w_next_leds = r_leds << 1;
          end else begin
            w_next_leds = r_leds >> 1;
          end
        end
      end
      BLINK:  w_next_leds = ~r_leds;
      default: w_next_leds = r_leds;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_leds   <= '0;
      r_mode   <= COUNT;
      r_dir    <= LEFT;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_req) begin
        r_mode <= w_mode_nxt;
        r_leds <= {{(W_LED-1){1'b0}}, init_lsb(w_mode_nxt)};
        r_dir  <= LEFT;
      end else if (w_step && !pause) begin
        r_leds   <= w_next_leds;
        r_dir    <= w_next_dir;
        r_strobe <= 1'b1;
      end
    end
  end

  assign leds        = r_leds;
  assign mode        = r_mode;
  assign step_strobe = r_strobe;

endmodule

`default_nettype wire
